// File: rtl/q2_sequencer.sv
// Q2 CPU instruction sequencer with a WIDTH-bit serial ALU and memory wait-state handshake.
// Optional single-step input is enabled by defining Q2_SEQ_STEP_EN.
module q2_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             dep_sw,
    input  logic             mem_rdy,
    input  logic [2:0]       opcode,
    input  logic             deref,
    input  logic             dbus_msb,
    input  logic             alu_cout,
    input  logic             x_lsb,
    input  logic             f_in,
`ifdef Q2_SEQ_STEP_EN
    input  logic             step,
`endif
    output logic             mem_req,
    output logic             rdp,
    output logic             rdx,
    output logic             rdm,
    output logic             rda,
    output logic             wro,
    output logic             wra,
    output logic             wrx,
    output logic             wrp,
    output logic             wrm,
    output logic             wrf,
    output logic             incp,
    output logic [1:0]       xh_sel,
    output logic             xl_sel,
    output logic             fout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        DEREF  = 3'd2,
        LOAD   = 3'd3,
        EXEC   = 3'd4,
        ALU    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             fetch_act;
    logic             dep_act;
    logic             dep_q;
    logic             dep_rise;
    logic             start;

    assign dep_rise = dep_sw & ~dep_q;

`ifdef Q2_SEQ_STEP_EN
    logic step_q;
    logic step_rise;
    assign step_rise = step & ~step_q;
    assign start     = run | step_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end
`else
    assign start = run;
`endif

    // fetch_act and dep_act mark an outstanding FETCH-state memory cycle; they
    // keep mem_req stable even if run or dep_sw change before mem_rdy arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= FETCH;
            cnt       <= '0;
            fetch_act <= 1'b0;
            dep_act   <= 1'b0;
            dep_q     <= 1'b0;
        end else begin
            dep_q <= dep_sw;
            case (st)
                FETCH: begin
                    if (fetch_act) begin
                        if (mem_rdy) begin
                            fetch_act <= 1'b0;
                            st        <= DECODE;
                        end
                    end else if (dep_act) begin
                        if (mem_rdy) dep_act <= 1'b0;
                    end else if (start) begin
                        fetch_act <= 1'b1;
                    end else if (dep_rise) begin
                        dep_act <= 1'b1;
                    end
                end
                DECODE: begin
                    if (deref)          st <= DEREF;
                    else if (opcode[2]) st <= EXEC;
                    else                st <= LOAD;
                end
                DEREF: begin
                    if (mem_rdy) st <= opcode[2] ? EXEC : LOAD;
                end
                LOAD: begin
                    if (mem_rdy) st <= EXEC;
                end
                EXEC: begin
                    if (!opcode[2]) begin
                        cnt <= '0;
                        st  <= ALU;
                    end else if (opcode[1:0] != 2'b01 || mem_rdy) begin
                        st        <= FETCH;
                        fetch_act <= run;
                    end
                end
                ALU: begin
                    if (cnt == LAST_BIT) begin
                        cnt       <= '0;
                        st        <= FETCH;
                        fetch_act <= run;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: st <= FETCH;
            endcase
        end
    end

    // Strobes are decoded from the registered state; memory strobes are
    // qualified by mem_rdy so they land in the completing cycle.
    always_comb begin
        mem_req = 1'b0;
        rdp     = 1'b0;
        rdx     = 1'b0;
        rdm     = 1'b0;
        rda     = 1'b0;
        wro     = 1'b0;
        wra     = 1'b0;
        wrx     = 1'b0;
        wrp     = 1'b0;
        wrm     = 1'b0;
        wrf     = 1'b0;
        incp    = 1'b0;
        xh_sel  = 2'd0;
        xl_sel  = 1'b0;
        fout    = 1'b0;
        case (st)
            FETCH: begin
                if (dep_act) begin
                    rdm     = 1'b1;
                    mem_req = 1'b1;
                    wrm     = mem_rdy;
                end else begin
                    rdp = 1'b1;
                    if (fetch_act) begin
                        mem_req = 1'b1;
                        if (mem_rdy) begin
                            wro    = 1'b1;
                            incp   = 1'b1;
                            wrx    = 1'b1;
                            xh_sel = dbus_msb ? 2'd2 : 2'd1;
                        end
                    end
                end
            end
            DEREF, LOAD: begin
                rdx     = 1'b1;
                mem_req = 1'b1;
                wrx     = mem_rdy;
            end
            EXEC: begin
                if (!opcode[2]) begin
                    wrf = 1'b1;
                    case (opcode[1:0])
                        2'b10:   fout = 1'b0;
                        2'b11:   fout = x_lsb;
                        default: fout = 1'b1;
                    endcase
                end else begin
                    case (opcode[1:0])
                        2'b01: begin
                            rda     = 1'b1;
                            mem_req = 1'b1;
                            wrm     = mem_rdy;
                        end
                        2'b10:   wrp = 1'b1;
                        2'b11:   wrp = ~f_in;
                        default: ;
                    endcase
                end
            end
            ALU: begin
                wra    = 1'b1;
                wrx    = 1'b1;
                wrf    = 1'b1;
                xh_sel = 2'd3;
                xl_sel = 1'b1;
                fout   = alu_cout;
            end
            default: ;
        endcase
    end

    assign state   = st;
    assign bit_cnt = cnt;

endmodule

// File: tb/tb_q2_sequencer.sv
// Randomized bench for q2_sequencer: builds the expected per-cycle output trace of each
// instruction from the instruction-level rules, then replays its stimulus against the DUT.
module tb_q2_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [3:0] RDP = 4'b1000, RDX = 4'b0100, RDM = 4'b0010, RDA = 4'b0001;
    localparam logic [6:0] WRO = 7'b1000000, WRA = 7'b0100000, WRX = 7'b0010000,
                           WRP = 7'b0001000, WRM = 7'b0000100, WRF = 7'b0000010,
                           INCP = 7'b0000001;
    localparam logic [22:0] IDLE_EXP = {3'd0, 1'b0, RDP, 7'd0, 2'd0, 1'b0, 1'b0, 4'd0};

    logic clk, rst_n, run, dep_sw, mem_rdy, deref, dbus_msb, alu_cout, x_lsb, f_in;
    logic [2:0] opcode;
    logic mem_req, rdp, rdx, rdm, rda, wro, wra, wrx, wrp, wrm, wrf, incp, xl_sel, fout;
    logic [1:0] xh_sel;
    logic [2:0] state;
    logic [CNT_W-1:0] bit_cnt;
`ifdef Q2_SEQ_STEP_EN
    logic step = 1'b0;
`endif

    q2_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .dep_sw(dep_sw), .mem_rdy(mem_rdy),
        .opcode(opcode), .deref(deref), .dbus_msb(dbus_msb), .alu_cout(alu_cout),
        .x_lsb(x_lsb), .f_in(f_in),
`ifdef Q2_SEQ_STEP_EN
        .step(step),
`endif
        .mem_req(mem_req), .rdp(rdp), .rdx(rdx), .rdm(rdm), .rda(rda),
        .wro(wro), .wra(wra), .wrx(wrx), .wrp(wrp), .wrm(wrm), .wrf(wrf), .incp(incp),
        .xh_sel(xh_sel), .xl_sel(xl_sel), .fout(fout), .state(state), .bit_cnt(bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run, dep, rdy, cout;
        logic [2:0]  op;
        logic        drf, msb, xl, f;
        logic [22:0] exp, mask;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   abort_at = -1;
    logic s_run, s_dep, need_idle;
    logic [2:0] n_op;
    logic n_drf, n_msb, n_xl, n_f;

    task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [22:0] sample();
        return {state, mem_req, rdp, rdx, rdm, rda, wro, wra, wrx, wrp, wrm, wrf, incp,
                xh_sel, xl_sel, fout, bit_cnt};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic int rw();
        return $urandom_range(0, 3);
    endfunction

    task automatic cyc(input logic [2:0] st, input logic req, input logic [3:0] rd,
                       input logic [6:0] wr, input logic [1:0] xh, input logic xl,
                       input logic fo, input logic [3:0] cnt, input logic rdy, input logic cout);
        rec_t r;
        r.run = s_run; r.dep = s_dep; r.rdy = rdy; r.cout = cout;
        r.op = n_op; r.drf = n_drf; r.msb = n_msb; r.xl = n_xl; r.f = n_f;
        r.exp  = {st, req, rd, wr, xh, xl, fo, cnt};
        r.mask = '1;
        if (!wr[4]) r.mask[7:5] = 3'b000;
        if (!wr[1]) r.mask[4]   = 1'b0;
        q.push_back(r);
    endtask

    task automatic idle();
        cyc(3'd0, 1'b0, RDP, 7'd0, 2'd0, 1'b0, 1'b0, 4'd0, rb(), rb());
    endtask

    task automatic mem_phase(input logic [2:0] st, input logic [3:0] rd, input int waits,
                             input logic [6:0] wr, input logic [1:0] xh);
        for (int k = 0; k < waits; k++)
            cyc(st, 1'b1, rd, 7'd0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, rb());
        cyc(st, 1'b1, rd, wr, xh, 1'b0, 1'b0, 4'd0, 1'b1, rb());
    endtask

    task automatic build(input int wf, input bit halt, input bit dep);
        logic c;
        s_run = 1'b1;
        s_dep = 1'b0;
        if (need_idle) begin
            idle();
            need_idle = 1'b0;
        end
        mem_phase(3'd0, RDP, wf, WRO | INCP | WRX, n_msb ? 2'd2 : 2'd1);
        if (halt) s_run = 1'b0;
        cyc(3'd1, 1'b0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0, 4'd0, rb(), rb());
        if (n_drf)    mem_phase(3'd2, RDX, rw(), WRX, 2'd0);
        if (!n_op[2]) mem_phase(3'd3, RDX, rw(), WRX, 2'd0);
        if (!n_op[2]) begin
            c = (n_op[1:0] == 2'b10) ? 1'b0 : (n_op[1:0] == 2'b11) ? n_xl : 1'b1;
            cyc(3'd4, 1'b0, 4'd0, WRF, 2'd0, 1'b0, c, 4'd0, rb(), rb());
            for (int k = 0; k < WIDTH; k++) begin
                c = rb();
                cyc(3'd5, 1'b0, 4'd0, WRA | WRX | WRF, 2'd3, 1'b1, c, 4'(k), rb(), c);
            end
        end else begin
            case (n_op[1:0])
                2'b01:   mem_phase(3'd4, RDA, rw(), WRM, 2'd0);
                2'b10:   cyc(3'd4, 1'b0, 4'd0, WRP, 2'd0, 1'b0, 1'b0, 4'd0, rb(), rb());
                2'b11:   cyc(3'd4, 1'b0, 4'd0, n_f ? 7'd0 : WRP, 2'd0, 1'b0, 1'b0, 4'd0, rb(), rb());
                default: cyc(3'd4, 1'b0, 4'd0, 7'd0, 2'd0, 1'b0, 1'b0, 4'd0, rb(), rb());
            endcase
        end
        if (halt) begin
            repeat ($urandom_range(1, 3)) idle();
            if (dep) begin
                s_dep = 1'b1;
                idle();
                s_dep = 1'b0;
                mem_phase(3'd0, RDM, (rw() == 0) ? 2 : rw(), WRM, 2'd0);
                idle();
            end
            need_idle = 1'b1;
        end
    endtask

    task automatic play();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            run = r.run; dep_sw = r.dep; mem_rdy = r.rdy; alu_cout = r.cout;
            opcode = r.op; deref = r.drf; dbus_msb = r.msb; x_lsb = r.xl; f_in = r.f;
            #1;
            check("cycle", sample() & r.mask, r.exp & r.mask);
            if (abort_at >= 0 && r.exp[22:20] == 3'd5 && r.exp[3:0] == 4'(abort_at)) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_alu", sample(), IDLE_EXP);
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("rst_release", sample(), IDLE_EXP);
                abort_at = -1;
            end
        end
    endtask

    initial begin
        int wf;
        bit halt, dep;
        rst_n = 1'b0; run = 1'b0; dep_sw = 1'b0; mem_rdy = 1'b0; opcode = 3'd0;
        deref = 1'b0; dbus_msb = 1'b0; alu_cout = 1'b0; x_lsb = 1'b0; f_in = 1'b0;
        need_idle = 1'b0;
        #1;
        check("reset", sample(), IDLE_EXP);
        run = 1'b1; mem_rdy = 1'b1; dep_sw = 1'b1;
        #1;
        check("reset_held", sample(), IDLE_EXP);
        dep_sw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release", sample(), IDLE_EXP);

        for (int i = 0; i < 60; i++) begin
            n_op = 3'($urandom); n_drf = rb(); n_msb = rb(); n_xl = rb(); n_f = rb();
            wf   = rw();
            halt = ($urandom_range(0, 3) == 0);
            dep  = rb();
            case (i)
                0:  begin n_op = 3'd2; n_drf = 1'b0; wf = 0; halt = 1'b0; end
                1:  wf = 3;
                2:  begin n_op = 3'd7; n_f = 1'b1; end
                3:  begin n_op = 3'd7; n_f = 1'b0; end
                4:  begin n_op = 3'd3; n_drf = 1'b1; n_xl = 1'b1; end
                5:  begin halt = 1'b1; dep = 1'b1; end
                20: begin n_op = 3'd2; halt = 1'b0; abort_at = 5; end
                default: ;
            endcase
            build(wf, halt, halt && dep);
            play();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

endmodule
